// File: rtl/ripple_cla_seq_if.sv
// ripple_cla_seq_if: start/result bus for the multi-cycle CLA adder.
//   master : requester (drives en, sub, A, B, c_in; receives results)
//   slave  : adder     (receives operands; drives Output, c_out, overflow, busy, ready)
// Parameter WIDTH must match the adder's WIDTH.
interface ripple_cla_seq_if #(parameter int WIDTH = 16);
  logic             en;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic [WIDTH-1:0] Output;
  logic             c_out;
  logic             overflow;
  logic             busy;
  logic             ready;

  modport master (output en, sub, A, B, c_in,
                  input  Output, c_out, overflow, busy, ready);
  modport slave  (input  en, sub, A, B, c_in,
                  output Output, c_out, overflow, busy, ready);
endinterface

// File: rtl/ripple_cla_seq.sv
// ripple_cla_seq: WIDTH-bit A+B+c_in adder evaluating one BLK-bit carry-lookahead
// group per clock, rippling the group carry LSB->MSB (NBLK = WIDTH/BLK cycles).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    ripple_cla_seq_if.slave: en/sub/A/B/c_in in; Output/c_out/overflow/busy/ready out
// Build option: define SUB_EN to make sub=1 compute A-B (B inverted, carry-in 1).
//   Without SUB_EN the sub input is ignored.

// One carry-lookahead group; c_msb is the carry into the group's top bit.
module ripple_cla_group #(parameter int BLK = 4) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           c_msb,
  output logic           co
);
  logic [BLK-1:0] g, p;
  logic [BLK:0]   c;
  logic           term, prod;

  // Each carry is the full sum-of-products of generate/propagate terms,
  // not a chain through the previous carry.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    prod = 1'b0;
    c[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      term = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = term | (prod & ci);
    end
  end

  assign s     = p ^ c[BLK-1:0];
  assign c_msb = c[BLK-1];
  assign co    = c[BLK];
endmodule

module ripple_cla_seq #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic          clk,
  input  logic          reset,
  ripple_cla_seq_if.slave bus
);
  localparam int NBLK = WIDTH / BLK;
  localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBLK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry, co_q, ov_q, busy_q, rdy_q;

  // Effective second operand and carry-in captured at start.
  logic [WIDTH-1:0] b_in;
  logic             ci_in;
`ifdef SUB_EN
  assign b_in  = bus.sub ? ~bus.B : bus.B;
  assign ci_in = bus.sub ? 1'b1   : bus.c_in;
`else
  assign b_in  = bus.B;
  assign ci_in = bus.c_in;
`endif

  logic [BLK-1:0] grp_s;
  logic           grp_cm, grp_co;

  ripple_cla_group #(.BLK(BLK)) u_grp (
    .a    (a_q[idx*BLK +: BLK]),
    .b    (b_q[idx*BLK +: BLK]),
    .ci   (carry),
    .s    (grp_s),
    .c_msb(grp_cm),
    .co   (grp_co)
  );

  // The DONE exit edge doubles as a start-sampling edge, so a held en
  // sustains one operation every NBLK+1 cycles.
  logic start;
  assign start = bus.en && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      co_q   <= 1'b0;
      ov_q   <= 1'b0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else if (start) begin
      a_q    <= bus.A;
      b_q    <= b_in;
      carry  <= ci_in;
      sum_q  <= '0;
      co_q   <= 1'b0;
      ov_q   <= 1'b0;
      idx    <= '0;
      busy_q <= 1'b1;
      rdy_q  <= 1'b0;
      state  <= RUN;
    end else begin
      case (state)
        RUN: begin
          sum_q[idx*BLK +: BLK] <= grp_s;
          carry                 <= grp_co;
          if (idx == LAST) begin
            co_q   <= grp_co;
            ov_q   <= grp_cm ^ grp_co;
            idx    <= '0;
            busy_q <= 1'b0;
            rdy_q  <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          rdy_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Output   = sum_q;
  assign bus.c_out    = co_q;
  assign bus.overflow = ov_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = rdy_q;
endmodule
